// File: rtl/nn_pkg.sv
// Shared definitions for the hidden-layer training datapath.
// Used by the hidden-neuron delta stage and by hidden_weight_update.
//   NN_W        data width of weights, activations and deltas
//   NN_FRAC     fractional bits (value = raw / 2^NN_FRAC)
//   NN_NUM_HID  hidden neurons
//   NN_NUM_IN   input features per hidden neuron
//   NN_LR_SHIFT learning rate = 2^-NN_LR_SHIFT
//   weight_t    signed weight, act_t unsigned activation / delta magnitude
package nn_pkg;

    localparam int NN_W        = 10;
    localparam int NN_FRAC     = 8;
    localparam int NN_NUM_HID  = 5;
    localparam int NN_NUM_IN   = 4;
    localparam int NN_LR_SHIFT = 2;

    typedef logic signed [NN_W-1:0] weight_t;
    typedef logic        [NN_W-1:0] act_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } upd_state_e;

endpackage

// File: rtl/weight_step_sat.sv
// Combinational single-weight gradient step with saturation.
//   w_i      current signed weight
//   delta_i  unsigned delta magnitude of the owning hidden neuron
//   x_i      unsigned input feature feeding this weight
//   sign_i   1 = delta is negative (weight moves up), 0 = weight moves down
//   w_new_o  updated weight, clamped to the signed W-bit range
module weight_step_sat
    import nn_pkg::*;
#(
    parameter int W        = NN_W,
    parameter int FRAC     = NN_FRAC,
    parameter int LR_SHIFT = NN_LR_SHIFT
) (
    input  logic signed [W-1:0] w_i,
    input  logic        [W-1:0] delta_i,
    input  logic        [W-1:0] x_i,
    input  logic                sign_i,
    output logic signed [W-1:0] w_new_o
);

    // Three guard bits cover w +/- step without overflow.
    localparam int SW    = W + 3;
    localparam int SHIFT = FRAC + LR_SHIFT;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic        [2*W-1:0] prod;
    logic        [SW-2:0]  step;
    logic signed [SW-1:0]  step_s;
    logic signed [SW-1:0]  w_ext;
    logic signed [SW-1:0]  sum;

    always_comb begin
        prod   = {{W{1'b0}}, delta_i} * {{W{1'b0}}, x_i};
        // Shift truncates toward zero: fractional product bits and the
        // learning-rate scaling are dropped together.
        step   = (SW-1)'(prod >> SHIFT);
        step_s = $signed({1'b0, step});
        w_ext  = {{(SW-W){w_i[W-1]}}, w_i};
        sum    = sign_i ? (w_ext + step_s) : (w_ext - step_s);

        if (sum > SAT_MAX) begin
            w_new_o = {1'b0, {(W-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            w_new_o = {1'b1, {(W-1){1'b0}}};
        end else begin
            w_new_o = sum[W-1:0];
        end
    end

endmodule

// File: rtl/hidden_weight_update.sv
// Input-to-hidden weight register file with a sequential gradient-descent
// update engine and a registered forward-pass read port.
//   clk, rst            clock, synchronous active-high reset
//   start               request an update pass (ignored while busy)
//   delta0, sign0       per-neuron delta magnitude and sign (1 = negative)
//   x_in                input features of the current sample
//   busy, done          pass in progress / one-cycle completion pulse
//   wr_en/hid/idx/data  weight initialisation write, honoured only when idle
//   rd_hid, rd_idx      read address
//   rd_weight           registered read data, 1-cycle latency
//
// Handshake: start is sampled only while busy=0. The sampling edge latches
// delta0/sign0/x_in and raises busy; those inputs are don't-care afterwards.
// One weight is rewritten per cycle (input index fastest). done pulses for
// one cycle as busy falls, and start may be reasserted in that same cycle.
module hidden_weight_update
    import nn_pkg::*;
#(
    parameter int NUM_IN   = NN_NUM_IN,
    parameter int NUM_HID  = NN_NUM_HID,
    parameter int W        = NN_W,
    parameter int FRAC     = NN_FRAC,
    parameter int LR_SHIFT = NN_LR_SHIFT,
    localparam int HW      = (NUM_HID > 1) ? $clog2(NUM_HID) : 1,
    localparam int IW      = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_HID-1:0][W-1:0]       delta0,
    input  logic [0:NUM_HID-1]              sign0,
    input  logic [NUM_IN-1:0][W-1:0]        x_in,
    output logic                            busy,
    output logic                            done,
    input  logic                            wr_en,
    input  logic [HW-1:0]                   wr_hid,
    input  logic [IW-1:0]                   wr_idx,
    input  logic signed [W-1:0]             wr_data,
    input  logic [HW-1:0]                   rd_hid,
    input  logic [IW-1:0]                   rd_idx,
    output logic signed [W-1:0]             rd_weight
);

    localparam logic [HW-1:0] J_LAST  = HW'(NUM_HID - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_IN - 1);
    localparam logic [HW:0]   HID_LIM = (HW+1)'(NUM_HID);
    localparam logic [IW:0]   IDX_LIM = (IW+1)'(NUM_IN);

    upd_state_e state_q, state_d;
    logic [HW-1:0] j_q, j_d;
    logic [IW-1:0] i_q, i_d;
    logic          done_q, done_d;

    logic [NUM_HID-1:0][W-1:0] delta_q;
    logic [0:NUM_HID-1]        sign_q;
    logic [NUM_IN-1:0][W-1:0]  x_q;

    logic signed [W-1:0] wmem_q [NUM_HID][NUM_IN];
    logic signed [W-1:0] rd_q;

    logic                latch_en;
    logic                upd_en;
    logic                mem_we;
    logic [HW-1:0]       mem_hid;
    logic [IW-1:0]       mem_idx;
    logic signed [W-1:0] mem_wdata;

    logic signed [W-1:0] cur_w;
    logic signed [W-1:0] new_w;
    logic                wr_in_range;
    logic                rd_in_range;

    assign wr_in_range = ({1'b0, wr_hid} < HID_LIM) && ({1'b0, wr_idx} < IDX_LIM);
    assign rd_in_range = ({1'b0, rd_hid} < HID_LIM) && ({1'b0, rd_idx} < IDX_LIM);

    assign cur_w = wmem_q[j_q][i_q];

    weight_step_sat #(
        .W        (W),
        .FRAC     (FRAC),
        .LR_SHIFT (LR_SHIFT)
    ) u_step (
        .w_i     (cur_w),
        .delta_i (delta_q[j_q]),
        .x_i     (x_q[i_q]),
        .sign_i  (sign_q[j_q]),
        .w_new_o (new_w)
    );

    // Next-state, counters and register-file write-port selection.
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        i_d       = i_q;
        done_d    = 1'b0;
        latch_en  = 1'b0;
        upd_en    = 1'b0;
        mem_we    = 1'b0;
        mem_hid   = wr_hid;
        mem_idx   = wr_idx;
        mem_wdata = wr_data;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_UPDATE;
                    j_d      = '0;
                    i_d      = '0;
                    latch_en = 1'b1;
                end
            end
            ST_UPDATE: begin
                upd_en = 1'b1;
                if (i_q == I_LAST) begin
                    i_d = '0;
                    if (j_q == J_LAST) begin
                        j_d     = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The update engine owns the write port while busy; an idle host
        // write lands on the same edge that may sample start, so the pass
        // starting there already sees the new value.
        if (upd_en) begin
            mem_we    = 1'b1;
            mem_hid   = j_q;
            mem_idx   = i_q;
            mem_wdata = new_w;
        end else if (state_q == ST_IDLE && wr_en && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            i_q     <= i_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta_q <= '0;
            sign_q  <= '0;
            x_q     <= '0;
        end else if (latch_en) begin
            delta_q <= delta0;
            sign_q  <= sign0;
            x_q     <= x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HID; h++) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    wmem_q[h][k] <= '0;
                end
            end
        end else if (mem_we) begin
            wmem_q[mem_hid][mem_idx] <= mem_wdata;
        end
    end

    // Read port sees the array before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_in_range) begin
            rd_q <= wmem_q[rd_hid][rd_idx];
        end else begin
            rd_q <= '0;
        end
    end

    assign busy      = (state_q == ST_UPDATE);
    assign done      = done_q;
    assign rd_weight = rd_q;

endmodule

// File: tb/tb_hidden_weight_update.sv
// Directed bench for hidden_weight_update with hand-computed expectations.
module tb_hidden_weight_update;

    localparam int NI   = 4;
    localparam int NH   = 5;
    localparam int W    = 10;
    localparam int NCYC = NH * NI;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [NH-1:0][W-1:0]   delta0;
    logic [0:NH-1]          sign0;
    logic [NI-1:0][W-1:0]   x_in;
    logic                   busy;
    logic                   done;
    logic                   wr_en;
    logic [2:0]             wr_hid;
    logic [1:0]             wr_idx;
    logic signed [W-1:0]    wr_data;
    logic [2:0]             rd_hid;
    logic [1:0]             rd_idx;
    logic signed [W-1:0]    rd_weight;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    hidden_weight_update dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .delta0    (delta0),
        .sign0     (sign0),
        .x_in      (x_in),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .wr_hid    (wr_hid),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_hid    (rd_hid),
        .rd_idx    (rd_idx),
        .rd_weight (rd_weight)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic read_w(input int h, input int i, output int v);
        @(negedge clk);
        rd_hid = h[2:0];
        rd_idx = i[1:0];
        @(negedge clk);
        v = int'(rd_weight);
    endtask

    task automatic write_w(input int h, input int i, input int v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_hid  = h[2:0];
        wr_idx  = i[1:0];
        wr_data = v[W-1:0];
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic check_w(input string tag, input int h, input int i, input int exp);
        int v;
        read_w(h, i, v);
        check(tag, v, exp);
    endtask

    // One pass with a single nonzero delta (neuron h) and a single nonzero
    // feature (input xi), so only w[h][xi] can move. Optional same-edge host
    // write, and an optional mid-pass injection at cycle inj_cyc after the
    // start edge: either a reset pulse or a start + write pair.
    task automatic run_pass(input string tag, input int h, input int d,
                            input int xi, input int xv, input bit s,
                            input bit wr_on, input int wh, input int wi, input int wv,
                            input int inj_cyc, input bit inj_rst, output int lat);
        @(negedge clk);
        delta0     = '0;
        x_in       = '0;
        sign0      = '0;
        delta0[h]  = d[W-1:0];
        x_in[xi]   = xv[W-1:0];
        sign0[h]   = s;
        start      = 1'b1;
        if (wr_on) begin
            wr_en   = 1'b1;
            wr_hid  = wh[2:0];
            wr_idx  = wi[1:0];
            wr_data = wv[W-1:0];
        end
        @(negedge clk);
        start  = 1'b0;
        wr_en  = 1'b0;
        delta0 = '1;
        x_in   = '1;
        sign0  = '1;
        check({tag, "_busy_start"}, int'(busy), 1);
        lat = -1;
        for (int k = 1; k <= 2 * NCYC; k++) begin
            @(negedge clk);
            if (k == inj_cyc) begin
                if (inj_rst) begin
                    rst = 1'b1;
                end else begin
                    start   = 1'b1;
                    wr_en   = 1'b1;
                    wr_hid  = 3'd4;
                    wr_idx  = 2'd0;
                    wr_data = -10'sd300;
                end
            end else if (k == inj_cyc + 1) begin
                rst   = 1'b0;
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (!inj_rst && k == NCYC - 1) check({tag, "_busy_last"}, int'(busy), 1);
            if (done) begin
                lat = k;
                check({tag, "_busy_at_done"}, int'(busy), 0);
                @(negedge clk);
                check({tag, "_done_1cyc"}, int'(done), 0);
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int dc;

        rst     = 1'b1;
        start   = 1'b0;
        delta0  = '0;
        sign0   = '0;
        x_in    = '0;
        wr_en   = 1'b0;
        wr_hid  = '0;
        wr_idx  = '0;
        wr_data = '0;
        rd_hid  = '0;
        rd_idx  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd", int'(rd_weight), 0);
        rst = 1'b0;

        for (int h = 0; h < NH; h++)
            for (int i = 0; i < NI; i++)
                check_w($sformatf("rst_w%0d%0d", h, i), h, i, 0);

        // Plain write/read, out-of-range read and dropped out-of-range write.
        write_w(1, 0, 100);
        check_w("wr_w10", 1, 0, 100);
        check_w("oor_rd50", 5, 0, 0);
        write_w(6, 1, 77);
        check_w("oor_rd61", 6, 1, 0);

        // 256*256 = 65536 >> 10 = 64; sign 0 subtracts.
        write_w(0, 0, 0);
        run_pass("t_basic", 0, 256, 0, 256, 1'b0, 1'b0, 0, 0, 0, -1, 1'b0, lat);
        check("t_basic_lat", lat, NCYC);
        check_w("t_basic_w00", 0, 0, -64);

        // 1023*1023 = 1046529 >> 10 = 1022; -500-1022 clamps to -512.
        write_w(1, 2, -500);
        run_pass("t_satlo", 1, 1023, 2, 1023, 1'b0, 1'b0, 0, 0, 0, -1, 1'b0, lat);
        check("t_satlo_lat", lat, NCYC);
        check_w("t_satlo_w12", 1, 2, -512);
        check_w("t_satlo_w00", 0, 0, -64);

        // 500+1022 clamps to 511.
        write_w(1, 2, 500);
        run_pass("t_sathi", 1, 1023, 2, 1023, 1'b1, 1'b0, 0, 0, 0, -1, 1'b0, lat);
        check_w("t_sathi_w12", 1, 2, 511);

        // 3*20 = 60 >> 10 = 0; weight unchanged.
        write_w(3, 1, 37);
        run_pass("t_trunc", 3, 3, 1, 20, 1'b1, 1'b0, 0, 0, 0, -1, 1'b0, lat);
        check_w("t_trunc_w31", 3, 1, 37);

        // 300*700 = 210000 >> 10 = 205; -100+205 = 105.
        write_w(2, 3, -100);
        run_pass("t_add", 2, 300, 3, 700, 1'b1, 1'b0, 0, 0, 0, -1, 1'b0, lat);
        check_w("t_add_w23", 2, 3, 105);
        check_w("t_add_w10", 1, 0, 100);

        // Write and start on the same edge: 512*256 >> 10 = 128; 256-128 = 128.
        run_pass("t_wrst", 0, 512, 1, 256, 1'b0, 1'b1, 0, 1, 256, -1, 1'b0, lat);
        check("t_wrst_lat", lat, NCYC);
        check_w("t_wrst_w01", 0, 1, 128);

        // Mid-pass start and write ignored: 512*128 >> 10 = 64; 200-64 = 136.
        write_w(4, 0, 200);
        dc = done_cnt;
        run_pass("t_mid", 4, 512, 0, 128, 1'b0, 1'b0, 0, 0, 0, 5, 1'b0, lat);
        check("t_mid_lat", lat, NCYC);
        repeat (3) @(negedge clk);
        check("t_mid_ndone", done_cnt - dc, 1);
        check_w("t_mid_w40", 4, 0, 136);

        // Reset at cycle 7 of a pass aborts it and clears every weight.
        dc = done_cnt;
        run_pass("t_rst", 0, 256, 0, 256, 1'b0, 1'b0, 0, 0, 0, 7, 1'b1, lat);
        check("t_rst_lat", lat, -1);
        check("t_rst_ndone", done_cnt - dc, 0);
        check("t_rst_busy", int'(busy), 0);
        for (int h = 0; h < NH; h++)
            for (int i = 0; i < NI; i++)
                check_w($sformatf("t_rst_w%0d%0d", h, i), h, i, 0);

        run_pass("t_after", 0, 256, 0, 256, 1'b0, 1'b0, 0, 0, 0, -1, 1'b0, lat);
        check("t_after_lat", lat, NCYC);
        check_w("t_after_w00", 0, 0, -64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
